// File: rtl/oam_dma_if.sv
// Core-side and system-bus-side signals of the sprite DMA controller.
// The DMA block takes the slave view; whoever models the core and bus takes the master view.
interface oam_dma_if;
   logic [15:0] cpu_a;
   logic [7:0]  cpu_d;
   logic        cpu_rw;
   logic        cpu_rdy;
   logic [15:0] bus_a;
   logic [7:0]  bus_d_out;
   logic [7:0]  bus_d_in;
   logic        bus_rw;
   logic        dma_active;

   modport slave (
      input  cpu_a, cpu_d, cpu_rw, bus_d_in,
      output cpu_rdy, bus_a, bus_d_out, bus_rw, dma_active
   );

   modport master (
      output cpu_a, cpu_d, cpu_rw, bus_d_in,
      input  cpu_rdy, bus_a, bus_d_out, bus_rw, dma_active
   );
endinterface

// File: rtl/oam_dma.sv
// Sprite DMA: a write to DMA_REG stalls the core and copies one 256-byte page to DEST_ADDR.
// The core passes straight through to the bus whenever no copy is running.
module oam_dma #(
   parameter logic [15:0] DMA_REG   = 16'h4014,
   parameter logic [15:0] DEST_ADDR = 16'h2004
) (
   input logic     clk,
   input logic     rst_n,
   oam_dma_if.slave io
);

   typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

   state_t     state;
   logic [7:0] page;
   logic [7:0] idx;
   logic [7:0] data_buf;
   logic       odd;

   // The core only honours a stall on a read, so HALT waits out any writes first.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         page     <= 8'h00;
         idx      <= 8'h00;
         data_buf <= 8'h00;
         odd      <= 1'b0;
      end else begin
         odd <= ~odd;
         case (state)
            IDLE: begin
               if (!io.cpu_rw && io.cpu_a == DMA_REG) begin
                  page  <= io.cpu_d;
                  idx   <= 8'h00;
                  state <= HALT;
               end
            end
            HALT: begin
               if (!io.cpu_rw) begin
                  if (io.cpu_a == DMA_REG) begin
                     page <= io.cpu_d;
                  end
               end else begin
                  state <= odd ? ALIGN : READ;
               end
            end
            ALIGN: begin
               state <= READ;
            end
            READ: begin
               data_buf <= io.bus_d_in;
               state    <= WRITE;
            end
            WRITE: begin
               idx   <= idx + 8'd1;
               state <= (idx == 8'hFF) ? IDLE : READ;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      io.cpu_rdy    = (state == IDLE);
      io.dma_active = 1'b0;
      io.bus_a      = io.cpu_a;
      io.bus_d_out  = io.cpu_d;
      io.bus_rw     = io.cpu_rw;
      case (state)
         ALIGN: begin
            io.dma_active = 1'b1;
            io.bus_rw     = 1'b1;
         end
         READ: begin
            io.dma_active = 1'b1;
            io.bus_a      = {page, idx};
            io.bus_rw     = 1'b1;
         end
         WRITE: begin
            io.dma_active = 1'b1;
            io.bus_a      = DEST_ADDR;
            io.bus_d_out  = data_buf;
            io.bus_rw     = 1'b0;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: doc/oam_dma.md
# oam_dma

Sprite-DMA controller that shares the CPU bus between the k6502 core and a 256-byte block-copy engine. A CPU write to the DMA trigger register stalls the core through `cpu_rdy`, then copies one 256-byte page to the sprite-data port with read/write pairs. The block sits between the core's address/data/rw pins and the system bus, and passes the CPU through untouched whenever no transfer is running.

## Interface
- `DMA_REG`, default 16'h4014: trigger register address; writing it selects the source page.
- `DEST_ADDR`, default 16'h2004: fixed destination address for every DMA write.
- `clk` in 1: system clock. All state changes on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low; sampled on the rising edge of `clk`.
- `cpu_a` in 16: core address.
- `cpu_d` in 8: core write data.
- `cpu_rw` in 1: core direction; 1 = read, 0 = write.
- `bus_d_in` in 8: read data returned by the system bus.
- `cpu_rdy` out 1: 1 = core may advance; 0 = core must repeat and hold its current cycle.
- `bus_a` out 16: system bus address.
- `bus_d_out` out 8: system bus write data.
- `bus_rw` out 1: system bus direction.
- `dma_active` out 1: 1 while the DMA engine owns the bus.

## Operation
- Registers:
  - `state`: IDLE, HALT, ALIGN, READ or WRITE.
  - `page[7:0]`, `idx[7:0]`, `buf[7:0]`.
  - `odd`: parity bit that toggles every clock.
- Reset values: state=IDLE, page=00, idx=00, buf=00, odd=0.
- Outputs during and after reset: cpu_rdy=1, dma_active=0, bus in passthrough.
- Passthrough (IDLE, HALT): bus_a=cpu_a, bus_d_out=cpu_d, bus_rw=cpu_rw.
- IDLE:
  - cpu_rdy=1.
  - Trigger: `cpu_rw==0 && cpu_a==DMA_REG`. On the trigger edge: page<=cpu_d, idx<=0, state<=HALT.
  - The trigger write itself is passed to the bus.
- HALT:
  - cpu_rdy=0; bus stays in passthrough.
  - cpu_rw==0: the core cannot stall on a write, so stay in HALT. If this write is again to DMA_REG, page<=cpu_d.
  - cpu_rw==1: the stall takes effect (the dummy read is repeated later). Go to ALIGN if odd==1 in this cycle, otherwise go to READ.
- ALIGN:
  - One dummy cycle: bus_a=cpu_a, bus_rw=1, cpu_rdy=0, dma_active=1.
  - Always goes to READ.
- READ:
  - bus_a={page,idx}, bus_rw=1, dma_active=1.
  - buf<=bus_d_in on the edge, then go to WRITE.
- WRITE:
  - bus_a=DEST_ADDR, bus_rw=0, bus_d_out=buf, dma_active=1.
  - idx<=idx+1 (8-bit).
  - If idx==8'hFF: go to IDLE. Otherwise go to READ.
- Arithmetic:
  - idx wraps FF→00 and never carries into page.
  - The source never crosses the page boundary; page FF reads FF00–FFFF.
- Outputs per state:
  - cpu_rdy = (state==IDLE).
  - dma_active = state ∈ {ALIGN, READ, WRITE}.
  - bus_d_out in ALIGN/READ = cpu_d; don't-care, but must not be X.
- Reset mid-transfer: the next edge with rst_n=0 forces IDLE. The partial copy is abandoned, and the next trigger restarts at idx=0.

## Timing
- All outputs are combinational decodes of registered state plus the passthrough inputs; there is no output register stage.
- Trigger write in cycle T: cpu_rdy=0 from T+1.
- Stall length:
  - Best case, core reads at T+1 with odd=0: HALT 1 cycle + 512 transfer cycles; cpu_rdy low for exactly 513 cycles.
  - With odd=1: 514 cycles.
  - Each extra core write cycle in HALT adds 1 cycle.
- Transfer ordering:
  - Cycles alternate READ, WRITE strictly: the read of byte n is immediately followed by the write of byte n.
  - 256 writes total, in idx order 00..FF.
- Release: cpu_rdy returns to 1 in the cycle after the final WRITE (idx FF).
  - A trigger in that same IDLE cycle starts a new transfer.
- odd toggles unconditionally every cycle, including during DMA; reset forces it to 0.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with cpu_a=1234, cpu_rw=1 → cpu_rdy=1, dma_active=0, bus_a=1234, bus_rw=1.
- Even trigger: write 02→4014, core reads next cycle with odd=0 → 1 HALT cycle, then READ 0200, WRITE 2004 with mem[0200], …, WRITE 2004 with mem[02FF]. cpu_rdy low for exactly 513 cycles.
- Odd trigger: same as the even case with odd=1 at the HALT read → one ALIGN cycle with bus_rw=1, bus_a=cpu_a. cpu_rdy low for 514 cycles; data identical to the even case.
- Writes in HALT: core issues 2 writes after the trigger (4014←03, then 0100←AA) → HALT lasts 3 cycles, both writes reach the bus, and the copy sources 0300–03FF.
- Reset mid-copy at idx=40 → IDLE and cpu_rdy=1 on the next cycle, no further DEST_ADDR writes. A later trigger with 05 copies from 0500 starting at idx=00.
- Page FF: trigger FF → reads FF00–FFFF, no access to 0000 after FFFF, returns to IDLE.
